eth_ptp_tag_ctrl: RTL and testbench
===================================

ETH_PTP_TAG_CTRL -- requirements
Module: eth_ptp_tag_ctrl

Interface
REQ-001 SHALL have parameters: SLOT_COUNT, default 8, number of outstanding TX timestamp slots (power of 2, 2..16).
REQ-002 SHALL have parameters: GEN_WIDTH 4 (per-slot generation bits), PTP_TAG_WIDTH 16, PTP_TS_WIDTH 96, COOKIE_WIDTH 16, TIMEOUT_WIDTH 16.
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: s_req_valid in 1; s_req_ready out 1; s_req_cookie in COOKIE_WIDTH -- per-frame timestamp request from host logic.
REQ-005 SHALL have ports: m_axis_tx_ptp_ts_tag out PTP_TAG_WIDTH; m_axis_tx_ptp_ts_valid out 1; m_axis_tx_ptp_ts_ready in 1 -- tag to MAC TX tag input.
REQ-006 SHALL have ports: s_axis_tx_ptp_ts_96 in PTP_TS_WIDTH; s_axis_tx_ptp_ts_tag in PTP_TAG_WIDTH; s_axis_tx_ptp_ts_valid in 1; s_axis_tx_ptp_ts_ready out 1 -- timestamps returned by MAC.
REQ-007 SHALL have ports: m_cpl_ts_96 out PTP_TS_WIDTH; m_cpl_cookie out COOKIE_WIDTH; m_cpl_timeout out 1; m_cpl_valid out 1; m_cpl_ready in 1 -- completions to host.
REQ-008 SHALL have ports: timeout_period in TIMEOUT_WIDTH (cycles, 0 = disabled); busy_count out log2(SLOT_COUNT)+1; stale_drop out 1 (one-cycle pulse).

Function
REQ-009 SHALL keep per slot: busy bit, cookie, GEN_WIDTH generation counter, TIMEOUT_WIDTH age counter.
REQ-010 Tag format SHALL be {zeros, gen, slot}: slot in bits [S-1:0], gen in bits [S+GEN_WIDTH-1:S], S = log2(SLOT_COUNT), remaining bits 0.
REQ-011 s_req_ready SHALL be 1 iff at least one slot is free (per registered state) and (m_axis_tx_ptp_ts_valid==0 or m_axis_tx_ptp_ts_ready==1).
REQ-012 On request handshake SHALL allocate the lowest-index free slot: busy=1, cookie stored, gen incremented modulo 2^GEN_WIDTH, age=0.
REQ-013 Tag register SHALL load the new tag with m_axis_tx_ptp_ts_valid=1 the cycle after the request handshake (latency 1); valid and tag SHALL hold stable until ready.
REQ-014 A slot freed in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-015 s_axis_tx_ptp_ts_ready SHALL equal (m_cpl_valid==0 or m_cpl_ready==1).
REQ-016 On timestamp handshake with tag slot busy, gen matching, and upper tag bits zero: SHALL load completion {ts, slot cookie, timeout=0}, m_cpl_valid=1 next cycle, free slot.
REQ-017 On timestamp handshake failing any REQ-016 check: SHALL drop it, produce no completion, pulse stale_drop for one cycle, change no slot state.
REQ-018 Each busy slot's age SHALL increment once per cycle, saturating at 2^TIMEOUT_WIDTH-1; free slots hold age 0.
REQ-019 A busy slot SHALL be expired when timeout_period!=0 and age>=timeout_period.
REQ-020 When completion register can load (REQ-015 condition) and no timestamp handshake occurs that cycle, the lowest-index expired slot SHALL be emitted as {ts=0, cookie, timeout=1} and freed.
REQ-021 Timestamp handshake SHALL have priority over timeout emission; a slot matched and expired in the same cycle SHALL complete normally (timeout=0).
REQ-022 Completion outputs SHALL hold stable while m_cpl_valid=1 and m_cpl_ready=0.
REQ-023 A timestamp arriving for a slot already timed out and reallocated SHALL fail the gen check and be dropped per REQ-017.
REQ-024 busy_count SHALL equal registered popcount of busy bits.
REQ-025 Changing timeout_period mid-operation SHALL take effect on the next cycle comparison; ages SHALL NOT reset.

Reset
REQ-026 While rst_n=0: all slots free, gen=0, age=0, cookies 0; m_axis_tx_ptp_ts_valid=0, m_axis_tx_ptp_ts_tag=0, m_cpl_valid=0, m_cpl_ts_96=0, m_cpl_cookie=0, m_cpl_timeout=0, stale_drop=0, busy_count=0.
REQ-027 Reset asserted mid-operation SHALL discard all outstanding slots and pending tag/completion with no completions emitted; after release s_req_ready=1 and s_axis_tx_ptp_ts_ready=1.

Verification
REQ-028 Request cookie 0xABCD after reset -> next cycle tag 0x0008 (gen 1, slot 0) valid; return ts 0x1234 with tag 0x0008 -> completion ts 0x1234, cookie 0xABCD, timeout 0, busy_count back to 0.
REQ-029 Eight requests with tag ready held 1 -> tags 0x0008..0x000F, busy_count=8, s_req_ready=0; ninth request stalls until a timestamp frees a slot, then takes that slot with gen 2.
REQ-030 timeout_period=100, request, no timestamp -> completion timeout=1, ts=0 when age reaches 100; late timestamp with old tag -> stale_drop pulse, no completion.
REQ-031 m_cpl_ready=0 with completion pending -> s_axis_tx_ptp_ts_ready=0, expired slots wait, outputs stable; ready=1 -> queued completions drain in order: timestamp first, then lowest expired slot.
REQ-032 Timestamp with tag 0x0108 (nonzero upper bits) or free slot -> stale_drop pulse, busy_count unchanged.
REQ-033 rst_n pulsed low with 3 busy slots and pending completion -> all outputs at REQ-026 values, busy_count=0, no completion after release.

Source files
------------

// File: rtl/eth_ptp_tag_ctrl.sv
// PTP TX timestamp tag controller: allocates generation-stamped tags to outgoing frames,
// matches returned MAC timestamps to host cookies, and retires slots that time out.
module eth_ptp_tag_ctrl #(
   parameter int SLOT_COUNT    = 8,
   parameter int GEN_WIDTH     = 4,
   parameter int PTP_TAG_WIDTH = 16,
   parameter int PTP_TS_WIDTH  = 96,
   parameter int COOKIE_WIDTH  = 16,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_req_valid,
   output logic                          s_req_ready,
   input  logic [COOKIE_WIDTH-1:0]       s_req_cookie,
   output logic [PTP_TAG_WIDTH-1:0]      m_axis_tx_ptp_ts_tag,
   output logic                          m_axis_tx_ptp_ts_valid,
   input  logic                          m_axis_tx_ptp_ts_ready,
   input  logic [PTP_TS_WIDTH-1:0]       s_axis_tx_ptp_ts_96,
   input  logic [PTP_TAG_WIDTH-1:0]      s_axis_tx_ptp_ts_tag,
   input  logic                          s_axis_tx_ptp_ts_valid,
   output logic                          s_axis_tx_ptp_ts_ready,
   output logic [PTP_TS_WIDTH-1:0]       m_cpl_ts_96,
   output logic [COOKIE_WIDTH-1:0]       m_cpl_cookie,
   output logic                          m_cpl_timeout,
   output logic                          m_cpl_valid,
   input  logic                          m_cpl_ready,
   input  logic [TIMEOUT_WIDTH-1:0]      timeout_period,
   output logic [$clog2(SLOT_COUNT):0]   busy_count,
   output logic                          stale_drop
);

   localparam int SW = $clog2(SLOT_COUNT);

   logic [SLOT_COUNT-1:0]    busy_q;
   logic [COOKIE_WIDTH-1:0]  cookie_q [SLOT_COUNT];
   logic [GEN_WIDTH-1:0]     gen_q    [SLOT_COUNT];
   logic [TIMEOUT_WIDTH-1:0] age_q    [SLOT_COUNT];

   logic                     free_any, exp_any;
   logic [SW-1:0]            free_idx, exp_idx;
   logic [GEN_WIDTH-1:0]     new_gen;
   logic [PTP_TAG_WIDTH-1:0] new_tag;
   logic [SW-1:0]            ts_slot;
   logic [GEN_WIDTH-1:0]     ts_gen;
   logic                     ts_hi_ok, ts_match;
   logic                     req_fire, ts_fire, ts_ok, to_fire;

   // Descending scans leave the lowest matching index as the winner.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      exp_any  = 1'b0;
      exp_idx  = '0;
      for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_any = 1'b1;
            free_idx = SW'(i);
         end
         if (busy_q[i] && timeout_period != '0 && age_q[i] >= timeout_period) begin
            exp_any = 1'b1;
            exp_idx = SW'(i);
         end
      end
   end

   always_comb begin
      busy_count = '0;
      for (int i = 0; i < SLOT_COUNT; i++) begin
         busy_count = busy_count + {{SW{1'b0}}, busy_q[i]};
      end
   end

   always_comb begin
      new_gen                      = gen_q[free_idx] + 1'b1;
      new_tag                      = '0;
      new_tag[SW-1:0]              = free_idx;
      new_tag[SW+GEN_WIDTH-1:SW]   = new_gen;
   end

   assign ts_slot  = s_axis_tx_ptp_ts_tag[SW-1:0];
   assign ts_gen   = s_axis_tx_ptp_ts_tag[SW+GEN_WIDTH-1:SW];
   assign ts_hi_ok = (s_axis_tx_ptp_ts_tag >> (SW + GEN_WIDTH)) == '0;
   assign ts_match = ts_hi_ok && busy_q[ts_slot] && (gen_q[ts_slot] == ts_gen);

   assign s_req_ready            = free_any && (!m_axis_tx_ptp_ts_valid || m_axis_tx_ptp_ts_ready);
   assign s_axis_tx_ptp_ts_ready = !m_cpl_valid || m_cpl_ready;

   assign req_fire = s_req_valid && s_req_ready;
   assign ts_fire  = s_axis_tx_ptp_ts_valid && s_axis_tx_ptp_ts_ready;
   assign ts_ok    = ts_fire && ts_match;
   // Any timestamp handshake, even a dropped one, blocks timeout emission that cycle.
   assign to_fire  = s_axis_tx_ptp_ts_ready && !ts_fire && exp_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q                 <= '0;
         m_axis_tx_ptp_ts_tag   <= '0;
         m_axis_tx_ptp_ts_valid <= 1'b0;
         m_cpl_ts_96            <= '0;
         m_cpl_cookie           <= '0;
         m_cpl_timeout          <= 1'b0;
         m_cpl_valid            <= 1'b0;
         stale_drop             <= 1'b0;
         for (int i = 0; i < SLOT_COUNT; i++) begin
            cookie_q[i] <= '0;
            gen_q[i]    <= '0;
            age_q[i]    <= '0;
         end
      end else begin
         stale_drop <= ts_fire && !ts_match;

         for (int i = 0; i < SLOT_COUNT; i++) begin
            if (busy_q[i] && age_q[i] != '1) begin
               age_q[i] <= age_q[i] + 1'b1;
            end
         end

         if (ts_ok) begin
            m_cpl_ts_96      <= s_axis_tx_ptp_ts_96;
            m_cpl_cookie     <= cookie_q[ts_slot];
            m_cpl_timeout    <= 1'b0;
            m_cpl_valid      <= 1'b1;
            busy_q[ts_slot]  <= 1'b0;
            age_q[ts_slot]   <= '0;
         end else if (to_fire) begin
            m_cpl_ts_96      <= '0;
            m_cpl_cookie     <= cookie_q[exp_idx];
            m_cpl_timeout    <= 1'b1;
            m_cpl_valid      <= 1'b1;
            busy_q[exp_idx]  <= 1'b0;
            age_q[exp_idx]   <= '0;
         end else if (m_cpl_ready) begin
            m_cpl_valid      <= 1'b0;
         end

         // Allocated slot was free, so it never collides with the slot freed above.
         if (req_fire) begin
            busy_q[free_idx]       <= 1'b1;
            cookie_q[free_idx]     <= s_req_cookie;
            gen_q[free_idx]        <= new_gen;
            age_q[free_idx]        <= '0;
            m_axis_tx_ptp_ts_tag   <= new_tag;
            m_axis_tx_ptp_ts_valid <= 1'b1;
         end else if (m_axis_tx_ptp_ts_ready) begin
            m_axis_tx_ptp_ts_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_eth_ptp_tag_ctrl.sv
// Scoreboard bench for eth_ptp_tag_ctrl: a slot-table reference model predicts tags,
// completions and drops; a negedge monitor checks every DUT handshake against the queues.
module tb_eth_ptp_tag_ctrl;

   localparam int SC = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         s_req_valid, s_req_ready;
   logic [15:0]  s_req_cookie;
   logic [15:0]  m_axis_tx_ptp_ts_tag;
   logic         m_axis_tx_ptp_ts_valid, m_axis_tx_ptp_ts_ready;
   logic [95:0]  s_axis_tx_ptp_ts_96;
   logic [15:0]  s_axis_tx_ptp_ts_tag;
   logic         s_axis_tx_ptp_ts_valid, s_axis_tx_ptp_ts_ready;
   logic [95:0]  m_cpl_ts_96;
   logic [15:0]  m_cpl_cookie;
   logic         m_cpl_timeout, m_cpl_valid, m_cpl_ready;
   logic [15:0]  timeout_period = '0;
   logic [3:0]   busy_count;
   logic         stale_drop;

   always #5 clk = ~clk;

   eth_ptp_tag_ctrl dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .s_req_valid            (s_req_valid),
      .s_req_ready            (s_req_ready),
      .s_req_cookie           (s_req_cookie),
      .m_axis_tx_ptp_ts_tag   (m_axis_tx_ptp_ts_tag),
      .m_axis_tx_ptp_ts_valid (m_axis_tx_ptp_ts_valid),
      .m_axis_tx_ptp_ts_ready (m_axis_tx_ptp_ts_ready),
      .s_axis_tx_ptp_ts_96    (s_axis_tx_ptp_ts_96),
      .s_axis_tx_ptp_ts_tag   (s_axis_tx_ptp_ts_tag),
      .s_axis_tx_ptp_ts_valid (s_axis_tx_ptp_ts_valid),
      .s_axis_tx_ptp_ts_ready (s_axis_tx_ptp_ts_ready),
      .m_cpl_ts_96            (m_cpl_ts_96),
      .m_cpl_cookie           (m_cpl_cookie),
      .m_cpl_timeout          (m_cpl_timeout),
      .m_cpl_valid            (m_cpl_valid),
      .m_cpl_ready            (m_cpl_ready),
      .timeout_period         (timeout_period),
      .busy_count             (busy_count),
      .stale_drop             (stale_drop)
   );

   typedef struct {
      logic [95:0] ts;
      logic [15:0] cookie;
      logic        to;
   } cpl_t;

   cpl_t        cpl_q[$];
   logic [15:0] tag_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_cpl_seen = 0;
   int          n_stale_seen = 0;

   // Reference model: slot table plus pending-output flags.
   bit          mb[SC];
   int          mg[SC];
   logic [15:0] mc[SC];
   int          ma[SC];
   bit          mtv, mcv, mst;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SC; i++) begin
         mb[i] = 0; mg[i] = 0; mc[i] = '0; ma[i] = 0;
      end
      mtv = 0; mcv = 0; mst = 0;
   endtask

   task automatic model_eval();
      int   nb = 0;
      int   fr = -1;
      int   al = -1;
      int   sl, gn, up;
      bit   er, etr, req_ok, ts_ok, load;
      cpl_t c;
      for (int i = 0; i < SC; i++) nb += int'(mb[i]);
      er  = (nb < SC) && (!mtv || m_axis_tx_ptp_ts_ready);
      etr = !mcv || m_cpl_ready;
      chk("req_ready", s_req_ready, er);
      chk("ts_ready", s_axis_tx_ptp_ts_ready, etr);
      chk("busy_count", busy_count, nb);
      chk("stale_drop", stale_drop, mst);
      chk("tag_valid", m_axis_tx_ptp_ts_valid, mtv);
      chk("cpl_valid", m_cpl_valid, mcv);
      req_ok = s_req_valid && er;
      ts_ok  = s_axis_tx_ptp_ts_valid && etr;
      mst    = 0;
      load   = 0;
      if (ts_ok) begin
         sl = int'(s_axis_tx_ptp_ts_tag) % SC;
         gn = (int'(s_axis_tx_ptp_ts_tag) / SC) % 16;
         up = int'(s_axis_tx_ptp_ts_tag) / (SC * 16);
         if (up == 0 && mb[sl] && mg[sl] == gn) begin
            c.ts = s_axis_tx_ptp_ts_96; c.cookie = mc[sl]; c.to = 1'b0;
            cpl_q.push_back(c);
            fr = sl; load = 1;
         end else begin
            mst = 1;
         end
      end else if (etr && timeout_period != 0) begin
         for (int i = 0; i < SC; i++) begin
            if (mb[i] && ma[i] >= int'(timeout_period)) begin
               c.ts = '0; c.cookie = mc[i]; c.to = 1'b1;
               cpl_q.push_back(c);
               fr = i; load = 1;
               break;
            end
         end
      end
      if (req_ok) begin
         for (int i = 0; i < SC; i++) begin
            if (!mb[i]) begin al = i; break; end
         end
         mg[al] = (mg[al] + 1) % 16;
         tag_q.push_back(16'(mg[al] * SC + al));
      end
      for (int i = 0; i < SC; i++) if (mb[i] && ma[i] < 65535) ma[i]++;
      if (fr >= 0) begin mb[fr] = 0; ma[fr] = 0; end
      if (al >= 0) begin mb[al] = 1; ma[al] = 0; mc[al] = s_req_cookie; end
      mcv = load ? 1'b1 : (m_cpl_ready ? 1'b0 : mcv);
      mtv = req_ok ? 1'b1 : (m_axis_tx_ptp_ts_ready ? 1'b0 : mtv);
   endtask

   // Monitor: pops expectations on each handshake and checks hold-while-stalled.
   initial begin
      bit          th = 0;
      bit          ch = 0;
      logic [15:0] st;
      cpl_t        sc;
      cpl_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            th = 0; ch = 0;
         end else begin
            if (th) chk("tag_hold", {m_axis_tx_ptp_ts_valid, m_axis_tx_ptp_ts_tag}, {1'b1, st});
            if (ch) chk("cpl_hold", {m_cpl_valid, m_cpl_ts_96, m_cpl_cookie, m_cpl_timeout},
                        {1'b1, sc.ts, sc.cookie, sc.to});
            th = m_axis_tx_ptp_ts_valid && !m_axis_tx_ptp_ts_ready;
            st = m_axis_tx_ptp_ts_tag;
            ch = m_cpl_valid && !m_cpl_ready;
            sc.ts = m_cpl_ts_96; sc.cookie = m_cpl_cookie; sc.to = m_cpl_timeout;
            if (m_axis_tx_ptp_ts_valid && m_axis_tx_ptp_ts_ready) begin
               if (tag_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL tag_unexpected: got 0x%0h, expected none", m_axis_tx_ptp_ts_tag);
               end else begin
                  chk("tag", m_axis_tx_ptp_ts_tag, tag_q.pop_front());
               end
            end
            if (m_cpl_valid && m_cpl_ready) begin
               n_cpl_seen++;
               if (cpl_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL cpl_unexpected: got cookie 0x%0h, expected none", m_cpl_cookie);
               end else begin
                  e = cpl_q.pop_front();
                  chk("cpl", {m_cpl_ts_96, m_cpl_cookie, m_cpl_timeout}, {e.ts, e.cookie, e.to});
               end
            end
            if (stale_drop) n_stale_seen++;
         end
      end
   end

   task automatic set_idle();
      s_req_valid = 0; s_req_cookie = '0; m_axis_tx_ptp_ts_ready = 1;
      s_axis_tx_ptp_ts_valid = 0; s_axis_tx_ptp_ts_tag = '0; s_axis_tx_ptp_ts_96 = '0;
      m_cpl_ready = 1;
   endtask

   task automatic step();
      #1;
      model_eval();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      set_idle();
      tag_q.delete();
      cpl_q.delete();
      model_reset();
      #1;
      chk("rst_tag", {m_axis_tx_ptp_ts_valid, m_axis_tx_ptp_ts_tag, stale_drop, busy_count}, '0);
      chk("rst_cpl", {m_cpl_valid, m_cpl_ts_96, m_cpl_cookie, m_cpl_timeout}, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1;
      #1;
      chk("rst_req_ready", s_req_ready, 1'b1);
      chk("rst_ts_ready", s_axis_tx_ptp_ts_ready, 1'b1);
   endtask

   task automatic send_ts(input logic [15:0] tag, input logic [95:0] ts);
      s_axis_tx_ptp_ts_valid = 1; s_axis_tx_ptp_ts_tag = tag; s_axis_tx_ptp_ts_96 = ts;
      step();
      s_axis_tx_ptp_ts_valid = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, base_st, k;
      int cand[$];
      int r;
      set_idle();
      #2;

      // Single round trip.
      do_reset();
      timeout_period = 0;
      s_req_valid = 1; s_req_cookie = 16'hABCD;
      step();
      s_req_valid = 0;
      chk("t1_first_tag", {m_axis_tx_ptp_ts_valid, m_axis_tx_ptp_ts_tag}, {1'b1, 16'h0008});
      base = n_cpl_seen;
      send_ts(16'h0008, 96'h1234);
      repeat (3) step();
      chk("t1_cpl_count", n_cpl_seen - base, 1);
      chk("t1_busy_zero", busy_count, 0);

      // Fill all slots, stall, then reuse the freed slot with the next generation.
      do_reset();
      s_req_valid = 1;
      for (int i = 0; i < 12; i++) begin
         s_req_cookie = 16'(16'h0100 + i);
         step();
      end
      chk("t2_busy8", busy_count, 8);
      chk("t2_stall", s_req_ready, 1'b0);
      send_ts(16'h000B, 96'h55);
      step();
      s_req_valid = 0;
      chk("t2_gen2_tag", {m_axis_tx_ptp_ts_valid, m_axis_tx_ptp_ts_tag}, {1'b1, 16'h0013});
      for (int i = 0; i < SC; i++) send_ts((i == 3) ? 16'h0013 : 16'(8 + i), 96'(i + 1));
      repeat (3) step();

      // Timeout then late stale timestamp.
      do_reset();
      timeout_period = 100;
      s_req_valid = 1; s_req_cookie = 16'h5A5A;
      step();
      s_req_valid = 0;
      base = n_cpl_seen;
      k = 0;
      while (k < 150 && n_cpl_seen == base) begin
         step();
         k++;
      end
      chk("t3_timeout_cpl", n_cpl_seen - base, 1);
      base_st = n_stale_seen;
      send_ts(16'h0008, 96'hDEAD);
      repeat (2) step();
      chk("t3_stale", n_stale_seen - base_st, 1);
      chk("t3_no_cpl", n_cpl_seen - base, 1);

      // Completion backpressure with expired slots queued behind a timestamp.
      do_reset();
      timeout_period = 10;
      s_req_valid = 1;
      for (int i = 0; i < 3; i++) begin
         s_req_cookie = 16'(16'h0031 + i);
         step();
      end
      s_req_valid = 0;
      m_cpl_ready = 0;
      base = n_cpl_seen;
      send_ts(16'h0008, 96'hBEEF);
      repeat (20) step();
      chk("t4_stalled", s_axis_tx_ptp_ts_ready, 1'b0);
      m_cpl_ready = 1;
      repeat (6) step();
      chk("t4_drained", n_cpl_seen - base, 3);

      // Bad upper bits and free-slot tags are dropped.
      do_reset();
      timeout_period = 0;
      s_req_valid = 1; s_req_cookie = 16'h0777;
      step();
      s_req_valid = 0;
      base_st = n_stale_seen;
      send_ts(16'h0108, 96'h1);
      send_ts(16'h0009, 96'h2);
      step();
      chk("t5_busy", busy_count, 1);
      chk("t5_stale", n_stale_seen - base_st, 2);
      send_ts(16'h0008, 96'h3);
      repeat (2) step();

      // Reset mid-operation with busy slots and a pending completion.
      s_req_valid = 1;
      for (int i = 0; i < 4; i++) begin
         s_req_cookie = 16'(16'h0900 + i);
         step();
      end
      s_req_valid = 0;
      m_cpl_ready = 0;
      send_ts(16'h0010, 96'h77);
      repeat (2) step();
      do_reset();
      base = n_cpl_seen;
      repeat (5) step();
      chk("t6_no_cpl", n_cpl_seen - base, 0);
      chk("t6_busy", busy_count, 0);

      // Randomised traffic with mid-run timeout changes.
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 800 == 0) begin
            r = $urandom_range(0, 4);
            timeout_period = (r == 0) ? 16'd0 : (r == 1) ? 16'd30 : (r == 2) ? 16'd6 :
                             (r == 3) ? 16'd200 : 16'd15;
         end
         s_req_valid  = ($urandom_range(0, 2) == 0);
         s_req_cookie = 16'($urandom);
         m_axis_tx_ptp_ts_ready = ($urandom_range(0, 3) != 0);
         m_cpl_ready  = ($urandom_range(0, 9) < 7);
         s_axis_tx_ptp_ts_valid = ($urandom_range(0, 9) < 3);
         s_axis_tx_ptp_ts_96 = {$urandom, $urandom, $urandom};
         cand.delete();
         for (int i = 0; i < SC; i++) if (mb[i]) cand.push_back(i);
         r = $urandom_range(0, 9);
         if (r < 7 && cand.size() > 0) begin
            k = cand[$urandom_range(0, cand.size() - 1)];
            s_axis_tx_ptp_ts_tag = 16'(mg[k] * SC + k);
         end else if (r < 9) begin
            s_axis_tx_ptp_ts_tag = 16'($urandom_range(0, 127));
         end else begin
            s_axis_tx_ptp_ts_tag = 16'($urandom);
         end
         step();
      end

      set_idle();
      timeout_period = 4;
      repeat (40) step();
      chk("end_tag_q_empty", tag_q.size(), 0);
      chk("end_cpl_q_empty", cpl_q.size(), 0);
      chk("end_busy", busy_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
